// File: rtl/instruction_encoder.sv
// instruction_encoder
// Accepts drawing commands over a valid/ready handshake, clamps the
// coordinates to the screen window, packs them into a 36-bit instruction
// word and queues the words in a DEPTH-entry FIFO for the decoder/ALU path.
// DEPTH must be a power of two, at least 2 (pointers wrap by overflow).
module instruction_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter logic [8:0]  X_MAX = 9'd319,
    parameter logic [7:0]  Y_MAX = 8'd239
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [8:0]               cmd_x1,
    input  logic [7:0]               cmd_y1,
    input  logic [8:0]               cmd_x2,
    input  logic [7:0]               cmd_y2,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [35:0]              instruction,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     clamp_flag
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;
    localparam logic [FW-1:0] FULL_COUNT = FW'(DEPTH);

    typedef enum logic [1:0] {
        OP_LD   = 2'b00,
        OP_RD   = 2'b01,
        OP_CD   = 2'b10,
        OP_DISP = 2'b11
    } op_e;

    logic [35:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [FW-1:0] r_fill;
    logic          r_clamp;

    op_e           w_op;
    logic [8:0]    w_x1;
    logic [7:0]    w_y1;
    logic [8:0]    w_x2;
    logic [7:0]    w_y2;
    logic          w_over;
    logic          w_clamp;
    logic [35:0]   w_word;
    logic          w_push;
    logic          w_pop;
    logic          w_not_empty;

    // Clamp coordinates to the window and build the packed instruction word
    always_comb begin
        w_op    = op_e'(cmd_op);
        w_x1    = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
        w_y1    = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
        w_x2    = (cmd_x2 > X_MAX) ? X_MAX : cmd_x2;
        w_y2    = (cmd_y2 > Y_MAX) ? Y_MAX : cmd_y2;
        w_over  = (cmd_x1 > X_MAX) || (cmd_y1 > Y_MAX) ||
                  (cmd_x2 > X_MAX) || (cmd_y2 > Y_MAX);
        w_word  = {cmd_op, w_x1, w_y1, w_x2, w_y2};
        w_clamp = w_over;
        // DISP carries no coordinates, so nothing can be clamped
        if (w_op == OP_DISP) begin
            w_word  = {2'b11, 34'h0};
            w_clamp = 1'b0;
        end
    end

    // Handshake qualifiers; cmd_ready depends on occupancy only, so a full
    // FIFO refuses a push even in a cycle where it pops
    always_comb begin
        w_not_empty = (r_fill != '0);
        cmd_ready   = (r_fill != FULL_COUNT);
        instr_valid = w_not_empty;
        w_push      = cmd_valid && cmd_ready;
        w_pop       = w_not_empty && instr_ready;
        instruction = w_not_empty ? r_mem[r_rd_ptr] : '0;
        fill        = r_fill;
        clamp_flag  = r_clamp;
    end

    // FIFO storage write; contents are masked by occupancy so need no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // Pointers, occupancy and clamp pulse; reset discards queued entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_clamp  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + FW'(1);
                2'b01:   r_fill <= r_fill - FW'(1);
                default: r_fill <= r_fill;
            endcase
            r_clamp <= w_push && w_clamp;
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: the driver queues the
// hand-computed word of every accepted command, the monitor pops and
// compares whenever the DUT hands a word downstream.
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [8:0]  cmd_x1;
    logic [7:0]  cmd_y1;
    logic [8:0]  cmd_x2;
    logic [7:0]  cmd_y2;
    logic        instr_valid;
    logic        instr_ready;
    logic [35:0] instruction;
    logic [2:0]  fill;
    logic        clamp_flag;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic [35:0] exp_q[$];
    logic [35:0] sb_exp;

    instruction_encoder #(.DEPTH(4), .X_MAX(9'd319), .Y_MAX(8'd239)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_x1      (cmd_x1),
        .cmd_y1      (cmd_y1),
        .cmd_x2      (cmd_x2),
        .cmd_y2      (cmd_y2),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .fill        (fill),
        .clamp_flag  (clamp_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%09h expected 0x%09h", name, act, exp);
    endtask

    // Monitor: a word is consumed at the next rising edge
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: got 0x%09h expected no word", instruction);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("sb_word", instruction, sb_exp);
            end
        end
    end

    // Offer one command until accepted; returns 1 time unit after the
    // accepting edge, where the clamp pulse must be visible
    task automatic send(input logic [1:0] op, input logic [8:0] x1, input logic [7:0] y1,
                        input logic [8:0] x2, input logic [7:0] y2,
                        input logic [35:0] ew, input logic ec);
        int unsigned n = 0;
        bit acc = 1'b0;
        cmd_op = op; cmd_x1 = x1; cmd_y1 = y1; cmd_x2 = x2; cmd_y2 = y2;
        cmd_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = 1'b1;
                exp_q.push_back(ew);
            end
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            n_total++;
            $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
        end else begin
            chk("clamp_flag", clamp_flag, ec);
        end
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((fill != 0 || exp_q.size() != 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_fill", fill, 0);
        chk("drain_sb_empty", exp_q.size(), 0);
    endtask

    task automatic wait_fill(input logic [2:0] target);
        int unsigned n = 0;
        while (fill != target && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_fill", fill, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; cmd_valid = 1'b0; instr_ready = 1'b0;
        cmd_op = 2'b00; cmd_x1 = '0; cmd_y1 = '0; cmd_x2 = '0; cmd_y2 = '0;
        #1 rst_n = 1'b0;
        #19;
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instruction, 36'h0);
        chk("rst_fill", fill, 0);
        chk("rst_clamp", clamp_flag, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", cmd_ready, 1);

        // Basic LD, consumed the cycle it appears
        instr_ready = 1'b1;
        send(2'b00, 9'd10, 8'd20, 9'd100, 8'd200, 36'h0142864C8, 1'b0);
        chk("ld_valid", instr_valid, 1);
        chk("ld_instr", instruction, 36'h0142864C8);
        chk("ld_fill", fill, 1);
        @(posedge clk); #1;
        chk("ld_fill_after", fill, 0);
        chk("ld_valid_after", instr_valid, 0);
        chk("ld_instr_after", instruction, 36'h0);

        // DISP ignores coordinates, even out-of-range ones
        send(2'b11, 9'd300, 8'd100, 9'd500, 8'd9, 36'hC00000000, 1'b0);
        drain();

        // CD with x1/y1 clamped; pulse lasts one cycle
        send(2'b10, 9'd400, 8'd250, 9'd5, 8'd5, 36'hA7FDE0505, 1'b1);
        @(posedge clk); #1;
        chk("clamp_drop", clamp_flag, 0);
        // Exactly at the limits: no clamp
        send(2'b01, 9'd319, 8'd239, 9'd0, 8'd0, 36'h67FDE0000, 1'b0);
        // One past the limits on the second point
        send(2'b00, 9'd0, 8'd0, 9'd320, 8'd240, 36'h000013FEF, 1'b1);
        drain();

        // Back-pressure: five pushes against a stalled consumer
        instr_ready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 5; k++) begin
                    logic [35:0] w;
                    w = 36'h400000000 | (36'(k) << 25) | 36'(k);
                    send(2'b01, 9'(k), 8'd0, 9'd0, 8'(k), w, 1'b0);
                end
            end
            begin
                wait_fill(3'd4);
                chk("full_ready", cmd_ready, 0);
                repeat (3) begin @(posedge clk); #1; end
                chk("full_hold_fill", fill, 4);
                chk("full_hold_valid", instr_valid, 1);
                chk("full_hold_instr", instruction, 36'h402000001);
                instr_ready = 1'b1;
            end
        join
        drain();

        // Full with simultaneous pop: pop only, push one cycle later
        instr_ready = 1'b0;
        send(2'b01, 9'd6, 8'd0, 9'd0, 8'd6, 36'h40C000006, 1'b0);
        send(2'b01, 9'd7, 8'd0, 9'd0, 8'd7, 36'h40E000007, 1'b0);
        send(2'b01, 9'd8, 8'd0, 9'd0, 8'd8, 36'h410000008, 1'b0);
        send(2'b01, 9'd9, 8'd0, 9'd0, 8'd9, 36'h412000009, 1'b0);
        chk("sim_fill4", fill, 4);
        instr_ready = 1'b1;
        fork
            send(2'b01, 9'd10, 8'd0, 9'd0, 8'd10, 36'h41400000A, 1'b0);
            begin
                @(posedge clk); #1;
                chk("sim_pop_only", fill, 3);
                chk("sim_ready", cmd_ready, 1);
                instr_ready = 1'b0;
                @(posedge clk); #1;
                chk("sim_push_next", fill, 4);
            end
        join
        instr_ready = 1'b1;
        drain();

        // Asynchronous reset with three entries queued
        instr_ready = 1'b0;
        send(2'b10, 9'd0, 8'd1, 9'd0, 8'd0, 36'h800020000, 1'b0);
        send(2'b10, 9'd0, 8'd2, 9'd0, 8'd0, 36'h800040000, 1'b0);
        send(2'b10, 9'd0, 8'd3, 9'd0, 8'd0, 36'h800060000, 1'b0);
        chk("mid_fill3", fill, 3);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_instr", instruction, 36'h0);
        chk("mid_rst_fill", fill, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b1;
        send(2'b00, 9'd1, 8'd2, 9'd3, 8'd4, 36'h002040304, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Command-side counterpart of the GPU instruction decoder: takes drawing commands (op code plus two endpoints) from the host/sequencer over a valid/ready handshake.
- Clamps coordinates to the screen window and packs each command into the 36-bit instruction word.
- Buffers packed words in a small FIFO and issues them to the decoder/ALU path over a second valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- X_MAX, 319, largest legal x coordinate; 9-bit value.
- Y_MAX, 239, largest legal y coordinate; 8-bit value.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  encoder can accept a command.
- cmd_op  input  2  00=LD line, 01=RD rectangle, 10=CD circle, 11=DISP.
- cmd_x1  input  9  first point x.
- cmd_y1  input  8  first point y.
- cmd_x2  input  9  second point x.
- cmd_y2  input  8  second point y.
- instr_valid  output  1  FIFO head holds a valid instruction.
- instr_ready  input  1  downstream consumes the head this cycle.
- instruction  output  36  packed word {op[35:34], x1[33:25], y1[24:17], x2[16:8], y2[7:0]}.
- fill  output  clog2(DEPTH)+1  current FIFO occupancy.
- clamp_flag  output  1  one-cycle pulse: the command accepted last cycle had at least one coordinate clamped.

Behaviour:
- Reset (rst_n low, asynchronous): read/write pointers and fill = 0, instr_valid = 0, instruction = 36'h0, clamp_flag = 0, cmd_ready = 1 once released. Reset mid-operation discards all queued entries immediately.
- Accept: push occurs when cmd_valid && cmd_ready.
- cmd_ready = (fill != DEPTH). It is combinational from fill only, never from instr_ready, so a full FIFO refuses a push even in a cycle when it pops.
- Pop: occurs when instr_valid && instr_ready. instr_valid = (fill != 0).
- instruction = entry at the read pointer when fill != 0, else 36'h0.
- Latency: a command accepted at edge N appears at the output after edge N, i.e. visible in cycle N+1 when the FIFO was empty. Order is strictly FIFO.
- Packing, LD/RD/CD:
  - x field = min(cmd_x, X_MAX).
  - y field = min(cmd_y, Y_MAX).
  - Unsigned compare, no wrap.
- Packing, DISP: all coordinate fields forced to 0 regardless of inputs. Word = {2'b11, 34'h0}. DISP never raises clamp_flag.
- clamp_flag: registered. It is high for exactly the one cycle after an accepting edge whose non-DISP command had any of x1 > X_MAX, y1 > Y_MAX, x2 > X_MAX, y2 > Y_MAX; low otherwise.
- Simultaneous push and pop (0 < fill < DEPTH): both occur, fill unchanged.
- Simultaneous push and pop with fill = 0: only the push occurs, because instr_valid is 0.
- Pointer wrap: pointers wrap modulo DEPTH.
- fill range: never exceeds DEPTH and never underflows.
- Output stability: while instr_valid = 1 and instr_ready = 0, instruction and instr_valid hold stable.
- Inputs are ignored when cmd_valid = 0 or cmd_ready = 0.

Test Plan:
- Basic LD: after reset, push LD (10,20)-(100,200) with instr_ready = 1 → next cycle instr_valid = 1, instruction = 36'h0142864C8; popped that cycle; fill returns to 0; clamp_flag stays 0.
- DISP: push DISP with x1 = 300, y1 = 100 → instruction = 36'hC00000000, clamp_flag = 0.
- Clamp: push CD with x1 = 400, y1 = 250, x2 = 5, y2 = 5 → x1 field = 319, y1 field = 239, clamp_flag high for one cycle.
- Back-pressure and full: hold instr_ready = 0 and push 5 distinct commands back-to-back.
  - Expected: first 4 accepted, cmd_ready = 0 with fill = 4, 5th held.
  - Then raise instr_ready: words drain in push order, the 5th enters after the first pop, and no command is lost or duplicated.
- Full with simultaneous pop: at fill = 4, assert instr_ready and cmd_valid in the same cycle → pop only, fill = 3; the push completes on the following cycle.
- Reset mid-operation: with fill = 3, drop rst_n asynchronously between edges → instr_valid = 0 and instruction = 0 immediately, fill = 0. After release, a new LD is the first word out.
